// File: rtl/hci_system_bank_arbiter.sv
// rtl/hci_system_bank_arbiter.sv - per-bank TCDM arbiter: high-priority port, round-robin low ports, starvation guard
module hci_system_bank_arbiter #(
  parameter int N_REQ                = 10,
  parameter int HI_IDX               = 8,
  parameter int MAX_STALL            = 4,
  parameter int AW                   = 11,
  parameter int DW                   = 32,
  parameter bit FILTER_WRITE_R_VALID = 1'b0,
  localparam int IW = $clog2(N_REQ),
  localparam int SW = $clog2(MAX_STALL + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [N_REQ-1:0]      req_i,
  output logic [N_REQ-1:0]      gnt_o,
  input  logic [N_REQ*AW-1:0]   add_i,
  input  logic [N_REQ-1:0]      wen_i,
  input  logic [N_REQ*DW/8-1:0] be_i,
  input  logic [N_REQ*DW-1:0]   data_i,
  output logic [N_REQ-1:0]      r_valid_o,
  output logic [DW-1:0]         r_data_o,
  output logic                  mem_req_o,
  output logic                  mem_wen_o,
  output logic [AW-1:0]         mem_add_o,
  output logic [DW/8-1:0]       mem_be_o,
  output logic [DW-1:0]         mem_wdata_o,
  input  logic [DW-1:0]         mem_rdata_i,
  output logic [SW-1:0]         stall_cnt_o
);

  if (N_REQ < 2 || HI_IDX < 0 || HI_IDX >= N_REQ || MAX_STALL < 1) begin : g_bad_params
    $error("hci_system_bank_arbiter: illegal N_REQ/HI_IDX/MAX_STALL");
  end

  localparam logic [N_REQ-1:0] HI_MASK = N_REQ'(1) << HI_IDX;

  logic [IW-1:0]    rr_q, rr_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic [N_REQ-1:0] r_valid_q, r_valid_d;
  logic [N_REQ-1:0] lo_req;
  logic             lo_pend, hi_win, lo_win, any_win;
  logic [IW-1:0]    lo_idx, win_idx;

  assign lo_req  = req_i & ~HI_MASK;
  assign lo_pend = |lo_req;

  // Walk downward so the last hit is the first requester at or after rr_q.
  always_comb begin
    lo_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (lo_req[(int'(rr_q) + i) % N_REQ]) begin
        lo_idx = IW'((int'(rr_q) + i) % N_REQ);
      end
    end
  end

  assign hi_win  = rst_ni & req_i[HI_IDX] & (~lo_pend | (stall_q < SW'(MAX_STALL)));
  assign lo_win  = rst_ni & ~hi_win & lo_pend;
  assign any_win = hi_win | lo_win;
  assign win_idx = hi_win ? IW'(HI_IDX) : lo_idx;

  assign gnt_o       = any_win ? (N_REQ'(1) << win_idx) : '0;
  assign mem_req_o   = rst_ni & (|req_i);
  assign mem_add_o   = any_win ? add_i[win_idx*AW +: AW] : '0;
  assign mem_wen_o   = any_win ? wen_i[win_idx] : 1'b0;
  assign mem_be_o    = any_win ? be_i[win_idx*(DW/8) +: DW/8] : '0;
  assign mem_wdata_o = any_win ? data_i[win_idx*DW +: DW] : '0;

  always_comb begin
    rr_d      = rr_q;
    stall_d   = '0;
    r_valid_d = gnt_o & (FILTER_WRITE_R_VALID ? wen_i : {N_REQ{1'b1}});
    if (lo_win) begin
      rr_d = (lo_idx == IW'(N_REQ - 1)) ? '0 : lo_idx + 1'b1;
    end else if (hi_win && lo_pend) begin
      stall_d = (stall_q == SW'(MAX_STALL)) ? stall_q : stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q      <= '0;
      stall_q   <= '0;
      r_valid_q <= '0;
    end else begin
      rr_q      <= rr_d;
      stall_q   <= stall_d;
      r_valid_q <= r_valid_d;
    end
  end

  // A response owed to the grant just before reset must never be seen.
  assign r_valid_o   = rst_ni ? r_valid_q : '0;
  assign r_data_o    = (|r_valid_o) ? mem_rdata_i : '0;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_hci_system_bank_arbiter.sv
// tb/tb_hci_system_bank_arbiter.sv - directed vector bench for hci_system_bank_arbiter
module tb_hci_system_bank_arbiter;
  localparam int N  = 4;
  localparam int AW = 11;
  localparam int DW = 32;

  logic clk, rst_n;
  logic [N-1:0]      req, wen;
  logic [N*AW-1:0]   add;
  logic [N*DW/8-1:0] be;
  logic [N*DW-1:0]   wdata;
  logic [DW-1:0]     rdata;

  logic [N-1:0]    gnt, rv, gnt_f, rv_f;
  logic [DW-1:0]   rd, rd_f, m_wd, m_wd_f;
  logic            m_req, m_wen, m_req_f, m_wen_f;
  logic [AW-1:0]   m_add, m_add_f;
  logic [DW/8-1:0] m_be, m_be_f;
  logic [1:0]      stall, stall_f;

  int tests = 0;
  int fails = 0;

  hci_system_bank_arbiter #(.N_REQ(N), .HI_IDX(3), .MAX_STALL(2), .AW(AW), .DW(DW),
                            .FILTER_WRITE_R_VALID(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .add_i(add), .wen_i(wen),
    .be_i(be), .data_i(wdata), .r_valid_o(rv), .r_data_o(rd), .mem_req_o(m_req),
    .mem_wen_o(m_wen), .mem_add_o(m_add), .mem_be_o(m_be), .mem_wdata_o(m_wd),
    .mem_rdata_i(rdata), .stall_cnt_o(stall));

  hci_system_bank_arbiter #(.N_REQ(N), .HI_IDX(3), .MAX_STALL(2), .AW(AW), .DW(DW),
                            .FILTER_WRITE_R_VALID(1'b1)) dut_f (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt_f), .add_i(add), .wen_i(wen),
    .be_i(be), .data_i(wdata), .r_valid_o(rv_f), .r_data_o(rd_f), .mem_req_o(m_req_f),
    .mem_wen_o(m_wen_f), .mem_add_o(m_add_f), .mem_be_o(m_be_f), .mem_wdata_o(m_wd_f),
    .mem_rdata_i(rdata), .stall_cnt_o(stall_f));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [N-1:0]  rv;
    logic [1:0]    stall;
    logic [AW-1:0] add;
    logic          mwen;
    logic          mreq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [3:0] q, logic [3:0] g, logic [3:0] v,
                              logic [1:0] s, logic [10:0] a, logic w, logic m);
    vec_t t;
    t.rst = r; t.req = q; t.gnt = g; t.rv = v; t.stall = s; t.add = a; t.mwen = w; t.mreq = m;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; wen = '1; rdata = '0;
    for (int k = 0; k < N; k++) begin
      add[k*AW +: AW]     = (k == 0) ? 11'h004 : 11'(16 * k);
      be[k*4 +: 4]        = (k == 0) ? 4'hF : 4'h0;
      wdata[k*DW +: DW]   = (k == 0) ? 32'hDEADBEEF : 32'h1111_1111 * k;
    end

    //          rst  req     gnt     rv      st  add     mwen mreq
    vecs.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, 0, 11'h000, 0, 0));
    vecs.push_back(mk(1, 4'b0010, 4'b0010, 4'b0000, 0, 11'h010, 1, 1));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0010, 0, 11'h000, 0, 0));
    vecs.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 0, 11'h020, 1, 1));
    vecs.push_back(mk(1, 4'b0111, 4'b0001, 4'b0100, 0, 11'h004, 1, 1));
    vecs.push_back(mk(1, 4'b0111, 4'b0010, 4'b0001, 0, 11'h010, 1, 1));
    vecs.push_back(mk(1, 4'b0111, 4'b0100, 4'b0010, 0, 11'h020, 1, 1));
    vecs.push_back(mk(1, 4'b0111, 4'b0001, 4'b0100, 0, 11'h004, 1, 1));
    vecs.push_back(mk(1, 4'b0101, 4'b0100, 4'b0001, 0, 11'h020, 1, 1));
    vecs.push_back(mk(1, 4'b0101, 4'b0001, 4'b0100, 0, 11'h004, 1, 1));
    vecs.push_back(mk(1, 4'b1001, 4'b1000, 4'b0001, 0, 11'h030, 1, 1));
    vecs.push_back(mk(1, 4'b1001, 4'b1000, 4'b1000, 1, 11'h030, 1, 1));
    vecs.push_back(mk(1, 4'b1001, 4'b0001, 4'b1000, 2, 11'h004, 1, 1));
    vecs.push_back(mk(1, 4'b1001, 4'b1000, 4'b0001, 0, 11'h030, 1, 1));
    vecs.push_back(mk(1, 4'b1001, 4'b1000, 4'b1000, 1, 11'h030, 1, 1));
    vecs.push_back(mk(1, 4'b1001, 4'b0001, 4'b1000, 2, 11'h004, 1, 1));
    vecs.push_back(mk(1, 4'b1100, 4'b1000, 4'b0001, 0, 11'h030, 1, 1));
    vecs.push_back(mk(1, 4'b1000, 4'b1000, 4'b1000, 1, 11'h030, 1, 1));
    vecs.push_back(mk(1, 4'b1000, 4'b1000, 4'b1000, 0, 11'h030, 1, 1));
    vecs.push_back(mk(1, 4'b1100, 4'b1000, 4'b1000, 0, 11'h030, 1, 1));
    vecs.push_back(mk(1, 4'b1100, 4'b1000, 4'b1000, 1, 11'h030, 1, 1));
    vecs.push_back(mk(1, 4'b1100, 4'b0100, 4'b1000, 2, 11'h020, 1, 1));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 4'b0100, 0, 11'h000, 0, 0));

    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      logic [31:0] exp_rd;
      rst_n = vecs[i].rst;
      req   = vecs[i].req;
      wen   = '1;
      rdata = 32'hCAFE_0000 + 32'(i);
      exp_rd = (vecs[i].rv != 0) ? rdata : 32'h0;
      #3;
      check($sformatf("v%0d gnt", i),      32'(gnt),   32'(vecs[i].gnt));
      check($sformatf("v%0d r_valid", i),  32'(rv),    32'(vecs[i].rv));
      check($sformatf("v%0d stall", i),    32'(stall), 32'(vecs[i].stall));
      check($sformatf("v%0d mem_add", i),  32'(m_add), 32'(vecs[i].add));
      check($sformatf("v%0d mem_wen", i),  32'(m_wen), 32'(vecs[i].mwen));
      check($sformatf("v%0d mem_req", i),  32'(m_req), 32'(vecs[i].mreq));
      check($sformatf("v%0d r_data", i),   rd,         exp_rd);
      next_cycle();
    end

    // Write from port 0, response filtered only on the second instance.
    rst_n = 1'b1; req = 4'b0001; wen = 4'b1110; rdata = 32'h1234_5678;
    #3;
    check("wr gnt",       32'(gnt),   32'h1);
    check("wr mem_wen",   32'(m_wen), 32'h0);
    check("wr mem_wdata", m_wd,       32'hDEADBEEF);
    check("wr mem_be",    32'(m_be),  32'hF);
    check("wr mem_add",   32'(m_add), 32'h4);
    next_cycle();
    req = '0; wen = '1;
    #3;
    check("wr r_valid",        32'(rv),   32'h1);
    check("wr r_data",         rd,        32'h1234_5678);
    check("wr r_valid filter", 32'(rv_f), 32'h0);
    check("wr r_data filter",  rd_f,      32'h0);
    next_cycle();

    // Port 2 read granted, then reset before its response.
    req = 4'b0100;
    #3;
    check("rst pre gnt", 32'(gnt), 32'h4);
    next_cycle();
    rst_n = 1'b0; req = '0;
    #3;
    check("rst r_valid", 32'(rv),    32'h0);
    check("rst gnt",     32'(gnt),   32'h0);
    check("rst mem_req", 32'(m_req), 32'h0);
    next_cycle();
    rst_n = 1'b1; req = 4'b0101;
    #3;
    check("post rst gnt",     32'(gnt),   32'h1);
    check("post rst r_valid", 32'(rv),    32'h0);
    check("post rst stall",   32'(stall), 32'h0);
    next_cycle();
    req = '0;
    #3;
    check("post rst resp", 32'(rv), 32'h1);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hci_system_bank_arbiter.md
Name: hci_system_bank_arbiter

Overview:
Per-bank arbiter that shares one single-port TCDM SRAM bank (1-cycle read latency, always ready) between N_REQ initiator ports.
- Ports: core/datamover ports, the external fill port, and one high-priority HWPE-side port.
- The high-priority port wins by default. Low-priority ports share the bank round-robin.
- A starvation counter forces a low-priority grant after MAX_STALL consecutive lost cycles.
- One instance sits in front of each of the N_BANKS banks in the log-interconnect-only configuration of the system.

Parameters:
N_REQ, 10, number of requester ports (N_CORE + N_HWPE + N_EXT); must be >= 2
HI_IDX, 8, index of the high-priority port; 0 <= HI_IDX < N_REQ
MAX_STALL, 4, max consecutive cycles low-priority requesters may lose to HI_IDX; must be >= 1 (elaboration assertion)
AW, 11, bank address width (clog2 of bank size in bytes)
DW, 32, data width
FILTER_WRITE_R_VALID, 0, 1 = no r_valid for writes

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
req_i  in  N_REQ  request per port
gnt_o  out  N_REQ  one-hot grant, combinational, same cycle as request
add_i  in  N_REQ*AW  packed addresses, port k at [k*AW +: AW]
wen_i  in  N_REQ  1 = read, 0 = write
be_i  in  N_REQ*DW/8  packed byte enables
data_i  in  N_REQ*DW  packed write data
r_valid_o  out  N_REQ  response valid, one-hot, registered
r_data_o  out  DW  read data, shared by all ports
mem_req_o  out  1  bank request
mem_wen_o  out  1  bank write-enable-n (1 = read)
mem_add_o  out  AW  bank address
mem_be_o  out  DW/8  bank byte enables
mem_wdata_o  out  DW  bank write data
mem_rdata_i  in  DW  bank read data, valid the cycle after a read
stall_cnt_o  out  clog2(MAX_STALL+1)  current starvation count (debug)

Behaviour:
Reset (rst_ni low at a rising edge):
- rr_q=0, stall_q=0, r_valid_o=0.
- While rst_ni is low: gnt_o=0 and mem_req_o=0 combinationally.
- A response owed to a grant in the cycle before reset is dropped. No r_valid_o appears after reset.

Low pending: lo_pend = |req_i over all k != HI_IDX.

Winner selection (combinational):
- If req_i[HI_IDX] and (!lo_pend or stall_q < MAX_STALL): winner = HI_IDX.
- Else if lo_pend: winner = the first k with req_i[k], k != HI_IDX, searching cyclically from rr_q upward with wrap at N_REQ.
- Else: no grant.

Grant and bank outputs:
- gnt_o = onehot(winner).
- mem_req_o = |req_i.
- mem_add_o, mem_wen_o, mem_be_o and mem_wdata_o are muxed from the winner; they are 0 when there is no winner.

Round-robin pointer:
- On a low-priority grant to port k: rr_q <= (k+1) mod N_REQ.
- Unchanged otherwise, including on HI grants.
- If rr_q == HI_IDX, the search simply skips it.

Starvation counter:
- stall_q <= stall_q+1 (saturating at MAX_STALL) when HI_IDX is granted while lo_pend.
- stall_q <= 0 on any low-priority grant, or when !lo_pend.

Responses:
- r_valid_o[k] is set exactly 1 cycle after gnt_o[k], for reads always and for writes only when FILTER_WRITE_R_VALID=0.
- r_data_o = mem_rdata_i whenever any r_valid_o is set, else 0.
- Back-to-back grants give back-to-back responses; throughput is 1 access per cycle.

Stability: inputs are sampled only in the granted cycle. A request not granted may change or drop without side effects.

Test Plan:
- Single request: N_REQ=4, HI_IDX=3, MAX_STALL=2; port 1 reads addr 0x10 for one cycle -> same cycle gnt_o=0010, mem_req_o=1, mem_wen_o=1, mem_add_o=0x10; next cycle r_valid_o=0010, r_data_o=mem_rdata_i.
- Round-robin: ports 0,1,2 request continuously -> grants 0,1,2,0,1,2; dropping port 1 for one cycle after the first 0 grant -> grants 0,2,0.
- Starvation: ports 3 (HI) and 0 request continuously -> grants 3,3,0,3,3,0; stall_cnt_o reads 0,1,2,0,1,2.
- Counter clear: HI and port 2 request for 1 cycle, then port 2 drops for 2 cycles while HI continues -> stall_cnt_o 0,1,0,0; with both requesting again, the next forced port-2 grant arrives only after 2 more HI grants.
- Write response: port 0 writes data 0xDEADBEEF, be 0xF, addr 0x4 -> mem_wen_o=0, mem_wdata_o=0xDEADBEEF; next cycle r_valid_o=0001 when FILTER_WRITE_R_VALID=0, 0000 when it is 1.
- Reset mid-operation: port 2 read granted, rst_ni low on the following edge -> r_valid_o stays 0000; after release with ports 0 and 2 requesting -> first grant goes to port 0 (rr_q=0).
